// File: rtl/tlul_req_arbiter.sv
// tlul_req_arbiter: round-robin TL-UL A-channel arbiter for three masters, with D-channel routing by source index.
// Optional macro ADDR_DECODE_ERR_EN adds address/opcode decode and a local error responder.
module tlul_req_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK = 32'hFFFF_F000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2:0]                m_a_valid,
  output logic [2:0]                m_a_ready,
  input  logic [3*OPCODE_WIDTH-1:0] m_a_opcode,
  input  logic [3*PARAM_WIDTH-1:0]  m_a_param,
  input  logic [3*SIZE_WIDTH-1:0]   m_a_size,
  input  logic [3*SRC_WIDTH-1:0]    m_a_source,
  input  logic [3*ADDR_WIDTH-1:0]   m_a_address,
  input  logic [3*MASK_WIDTH-1:0]   m_a_mask,
  input  logic [3*DATA_WIDTH-1:0]   m_a_data,
  output logic [2:0]                m_d_valid,
  input  logic [2:0]                m_d_ready,
  output logic [3*OPCODE_WIDTH-1:0] m_d_opcode,
  output logic [3*PARAM_WIDTH-1:0]  m_d_param,
  output logic [3*SIZE_WIDTH-1:0]   m_d_size,
  output logic [3*SRC_WIDTH-1:0]    m_d_source,
  output logic [3*SINK_WIDTH-1:0]   m_d_sink,
  output logic [3*DATA_WIDTH-1:0]   m_d_data,
  output logic [2:0]                m_d_error,
  output logic                      s_a_valid,
  input  logic                      s_a_ready,
  output logic [OPCODE_WIDTH-1:0]   s_a_opcode,
  output logic [PARAM_WIDTH-1:0]    s_a_param,
  output logic [SIZE_WIDTH-1:0]     s_a_size,
  output logic [SRC_WIDTH-1:0]      s_a_source,
  output logic [ADDR_WIDTH-1:0]     s_a_address,
  output logic [MASK_WIDTH-1:0]     s_a_mask,
  output logic [DATA_WIDTH-1:0]     s_a_data,
  input  logic                      s_d_valid,
  output logic                      s_d_ready,
  input  logic [OPCODE_WIDTH-1:0]   s_d_opcode,
  input  logic [PARAM_WIDTH-1:0]    s_d_param,
  input  logic [SIZE_WIDTH-1:0]     s_d_size,
  input  logic [SRC_WIDTH-1:0]      s_d_source,
  input  logic [SINK_WIDTH-1:0]     s_d_sink,
  input  logic [DATA_WIDTH-1:0]     s_d_data,
  input  logic                      s_d_error,
  output logic                      err_unexpected_d
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              pending_q, pending_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic                    active_q;
  logic [3*SRC_WIDTH-1:0]  orig_src_q;
  logic [1:0]              hold_idx_q;
  logic [OPCODE_WIDTH-1:0] hold_opcode_q;
  logic [PARAM_WIDTH-1:0]  hold_param_q;
  logic [SIZE_WIDTH-1:0]   hold_size_q;
  logic [ADDR_WIDTH-1:0]   hold_address_q;
  logic [MASK_WIDTH-1:0]   hold_mask_q;
  logic [DATA_WIDTH-1:0]   hold_data_q;

  logic [2:0] eligible;
  logic [1:0] pri1, pri2;
  logic       grant_any;
  logic [1:0] grant_idx;
  logic       accept;
  logic       req_bad;
  logic       err_block;
  logic [1:0] d_idx;
  logic [3:0] pend4;
  logic       d_hit;
  logic       d_fire;

  // Search order starts just after the last winner; rr_ptr itself is checked last.
  always_comb begin
    eligible  = m_a_valid & ~pending_q;
    pri1      = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    pri2      = (pri1 == 2'd2) ? 2'd0 : pri1 + 2'd1;
    grant_any = 1'b1;
    grant_idx = rr_ptr_q;
    if (eligible[pri1])          grant_idx = pri1;
    else if (eligible[pri2])     grant_idx = pri2;
    else if (eligible[rr_ptr_q]) grant_idx = rr_ptr_q;
    else                         grant_any = 1'b0;
  end

`ifdef ADDR_DECODE_ERR_EN
  logic                    err_pend_q;
  logic [1:0]              err_idx_q;
  logic                    err_get_q;
  logic [SIZE_WIDTH-1:0]   err_size_q;
  logic [OPCODE_WIDTH-1:0] g_opcode;
  logic [ADDR_WIDTH-1:0]   g_address;
  logic                    err_fire;

  assign g_opcode  = m_a_opcode[grant_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign g_address = m_a_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign req_bad   = ((g_address & SLAVE_MASK) != SLAVE_BASE) ||
                     !((g_opcode == OPCODE_WIDTH'(0)) || (g_opcode == OPCODE_WIDTH'(1)) ||
                       (g_opcode == OPCODE_WIDTH'(4)));
  assign err_block = err_pend_q;
  assign err_fire  = err_pend_q && m_d_ready[err_idx_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pend_q <= 1'b0;
      err_idx_q  <= 2'd0;
      err_get_q  <= 1'b0;
      err_size_q <= '0;
    end else if (accept && req_bad) begin
      err_pend_q <= 1'b1;
      err_idx_q  <= grant_idx;
      err_get_q  <= (g_opcode == OPCODE_WIDTH'(4));
      err_size_q <= m_a_size[grant_idx*SIZE_WIDTH +: SIZE_WIDTH];
    end else if (err_fire) begin
      err_pend_q <= 1'b0;
    end
  end
`else
  assign req_bad   = 1'b0;
  assign err_block = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    m_a_ready = 3'b000;
    s_a_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (active_q && grant_any && !err_block) begin
          m_a_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          rr_ptr_d             = grant_idx;
          pending_d[grant_idx] = 1'b1;
          if (!req_bad) state_d = HOLD;
        end
      end
      HOLD: begin
        s_a_valid = 1'b1;
        if (s_a_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (d_fire) pending_d[d_idx] = 1'b0;
`ifdef ADDR_DECODE_ERR_EN
    if (err_fire) pending_d[err_idx_q] = 1'b0;
`endif
  end

  // active_q keeps every handshake output low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 3'b000;
      rr_ptr_q  <= 2'd2;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      active_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      orig_src_q     <= '0;
      hold_idx_q     <= 2'd0;
      hold_opcode_q  <= '0;
      hold_param_q   <= '0;
      hold_size_q    <= '0;
      hold_address_q <= '0;
      hold_mask_q    <= '0;
      hold_data_q    <= '0;
    end else if (accept) begin
      orig_src_q[grant_idx*SRC_WIDTH +: SRC_WIDTH] <= m_a_source[grant_idx*SRC_WIDTH +: SRC_WIDTH];
      hold_idx_q     <= grant_idx;
      hold_opcode_q  <= m_a_opcode[grant_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
      hold_param_q   <= m_a_param[grant_idx*PARAM_WIDTH +: PARAM_WIDTH];
      hold_size_q    <= m_a_size[grant_idx*SIZE_WIDTH +: SIZE_WIDTH];
      hold_address_q <= m_a_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      hold_mask_q    <= m_a_mask[grant_idx*MASK_WIDTH +: MASK_WIDTH];
      hold_data_q    <= m_a_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign s_a_opcode  = hold_opcode_q;
  assign s_a_param   = hold_param_q;
  assign s_a_size    = hold_size_q;
  assign s_a_source  = SRC_WIDTH'(hold_idx_q);
  assign s_a_address = hold_address_q;
  assign s_a_mask    = hold_mask_q;
  assign s_a_data    = hold_data_q;

  // A D beat is routed only to a master that is actually waiting on the downstream slave.
  assign d_idx = s_d_source[1:0];
  assign pend4 = {1'b0, pending_q};
`ifdef ADDR_DECODE_ERR_EN
  assign d_hit = active_q && pend4[d_idx] && !(err_pend_q && (err_idx_q == d_idx));
`else
  assign d_hit = active_q && pend4[d_idx];
`endif

  always_comb begin
    m_d_valid        = 3'b000;
    s_d_ready        = 1'b0;
    err_unexpected_d = 1'b0;
    d_fire           = 1'b0;
    m_d_source       = orig_src_q;
    m_d_opcode       = {3{s_d_opcode}};
    m_d_param        = {3{s_d_param}};
    m_d_size         = {3{s_d_size}};
    m_d_sink         = {3{s_d_sink}};
    m_d_data         = {3{s_d_data}};
    m_d_error        = {3{s_d_error}};
    if (d_hit) begin
      m_d_valid[d_idx] = s_d_valid;
      s_d_ready        = m_d_ready[d_idx];
      d_fire           = s_d_valid && m_d_ready[d_idx];
    end else if (active_q) begin
      s_d_ready        = 1'b1;
      err_unexpected_d = s_d_valid;
    end
`ifdef ADDR_DECODE_ERR_EN
    if (err_pend_q) begin
      m_d_valid[err_idx_q] = 1'b1;
      m_d_opcode[err_idx_q*OPCODE_WIDTH +: OPCODE_WIDTH] = err_get_q ? OPCODE_WIDTH'(1) : '0;
      m_d_param[err_idx_q*PARAM_WIDTH +: PARAM_WIDTH]    = '0;
      m_d_size[err_idx_q*SIZE_WIDTH +: SIZE_WIDTH]       = err_size_q;
      m_d_sink[err_idx_q*SINK_WIDTH +: SINK_WIDTH]       = '0;
      m_d_data[err_idx_q*DATA_WIDTH +: DATA_WIDTH]       = '0;
      m_d_error[err_idx_q]                               = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_tlul_req_arbiter.sv
// tb_tlul_req_arbiter: scoreboard bench for tlul_req_arbiter; expected A/D beats are queued at drive time.
// The decode-error scenario runs only when ADDR_DECODE_ERR_EN is defined.
module tb_tlul_req_arbiter;
  localparam int AW = 32, DW = 32, MW = 4, ZW = 3, SW = 2, KW = 1, OW = 3, PW = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      m_a_valid, m_a_ready;
  logic [3*OW-1:0] m_a_opcode;
  logic [3*PW-1:0] m_a_param;
  logic [3*ZW-1:0] m_a_size;
  logic [3*SW-1:0] m_a_source;
  logic [3*AW-1:0] m_a_address;
  logic [3*MW-1:0] m_a_mask;
  logic [3*DW-1:0] m_a_data;
  logic [2:0]      m_d_valid, m_d_ready, m_d_error;
  logic [3*OW-1:0] m_d_opcode;
  logic [3*PW-1:0] m_d_param;
  logic [3*ZW-1:0] m_d_size;
  logic [3*SW-1:0] m_d_source;
  logic [3*KW-1:0] m_d_sink;
  logic [3*DW-1:0] m_d_data;
  logic            s_a_valid, s_a_ready;
  logic [OW-1:0]   s_a_opcode;
  logic [PW-1:0]   s_a_param;
  logic [ZW-1:0]   s_a_size;
  logic [SW-1:0]   s_a_source;
  logic [AW-1:0]   s_a_address;
  logic [MW-1:0]   s_a_mask;
  logic [DW-1:0]   s_a_data;
  logic            s_d_valid, s_d_ready, s_d_error;
  logic [OW-1:0]   s_d_opcode;
  logic [PW-1:0]   s_d_param;
  logic [ZW-1:0]   s_d_size;
  logic [SW-1:0]   s_d_source;
  logic [KW-1:0]   s_d_sink;
  logic [DW-1:0]   s_d_data;
  logic            err_unexpected_d;

  always #5 clk = ~clk;

  tlul_req_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode), .m_a_param(m_a_param),
    .m_a_size(m_a_size), .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode), .m_d_param(m_d_param),
    .m_d_size(m_d_size), .m_d_source(m_d_source), .m_d_sink(m_d_sink), .m_d_data(m_d_data),
    .m_d_error(m_d_error),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode), .s_a_param(s_a_param),
    .s_a_size(s_a_size), .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode), .s_d_param(s_d_param),
    .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_sink(s_d_sink), .s_d_data(s_d_data),
    .s_d_error(s_d_error), .err_unexpected_d(err_unexpected_d)
  );

  typedef struct {
    logic [SW-1:0] src;
    logic [AW-1:0] addr;
    logic [OW-1:0] opcode;
    logic [DW-1:0] data;
  } aBeat_t;

  typedef struct {
    int            master;
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    logic [OW-1:0] opcode;
    logic          err;
  } dBeat_t;

  aBeat_t aQueue[$];
  dBeat_t dQueue[$];
  int vectorCount = 0;
  int missCount   = 0;
  int order[6]    = '{0, 1, 2, 0, 1, 2};
  int prev;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [OW-1:0] op, input logic [SW-1:0] src,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m_a_opcode[idx*OW +: OW]  = op;
    m_a_param[idx*PW +: PW]   = '0;
    m_a_size[idx*ZW +: ZW]    = 3'd2;
    m_a_source[idx*SW +: SW]  = src;
    m_a_address[idx*AW +: AW] = addr;
    m_a_mask[idx*MW +: MW]    = '1;
    m_a_data[idx*DW +: DW]    = data;
    m_a_valid[idx]            = 1'b1;
  endtask

  task automatic expectA(input logic [SW-1:0] src, input logic [AW-1:0] addr,
                         input logic [OW-1:0] op, input logic [DW-1:0] data);
    aQueue.push_back('{src: src, addr: addr, opcode: op, data: data});
  endtask

  task automatic expectD(input int master, input logic [SW-1:0] src, input logic [DW-1:0] data,
                         input logic [OW-1:0] op, input logic err);
    dQueue.push_back('{master: master, src: src, data: data, opcode: op, err: err});
  endtask

  task automatic driveD(input logic [SW-1:0] src, input logic [DW-1:0] data, input logic [OW-1:0] op);
    s_d_valid  = 1'b1;
    s_d_source = src;
    s_d_data   = data;
    s_d_opcode = op;
  endtask

  task automatic checkA();
    aBeat_t e;
    checkOutput("s_a_valid", 64'(s_a_valid), 64'd1);
    if (aQueue.size() == 0) begin
      checkOutput("a_sb_empty", 64'(aQueue.size()), 64'd1);
      return;
    end
    e = aQueue.pop_front();
    checkOutput("s_a_source", 64'(s_a_source), 64'(e.src));
    checkOutput("s_a_address", 64'(s_a_address), 64'(e.addr));
    checkOutput("s_a_opcode", 64'(s_a_opcode), 64'(e.opcode));
    checkOutput("s_a_data", 64'(s_a_data), 64'(e.data));
    checkOutput("s_a_size", 64'(s_a_size), 64'd2);
  endtask

  task automatic checkD();
    dBeat_t e;
    if (dQueue.size() == 0) begin
      checkOutput("d_sb_empty", 64'(m_d_valid), 64'd0);
      return;
    end
    e = dQueue.pop_front();
    checkOutput("m_d_valid", 64'(m_d_valid), 64'd1 << e.master);
    checkOutput("m_d_source", 64'(m_d_source[e.master*SW +: SW]), 64'(e.src));
    checkOutput("m_d_data", 64'(m_d_data[e.master*DW +: DW]), 64'(e.data));
    checkOutput("m_d_opcode", 64'(m_d_opcode[e.master*OW +: OW]), 64'(e.opcode));
    checkOutput("m_d_error", 64'(m_d_error[e.master]), 64'(e.err));
  endtask

  // Bounded wait for any m_a_ready; a timeout shows up as a grant miscompare.
  task automatic waitGrant(input int idx);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_a_ready != 3'b000) break;
    end
    checkOutput("grant", 64'(m_a_ready), 64'd1 << idx);
  endtask

  task automatic applyReset();
    reset_n    = 1'b0;
    m_a_valid  = 3'b111;
    driveD(2'd0, 32'h0, 3'd0);
    #1;
    @(negedge clk);
    checkOutput("rst_m_a_ready", 64'(m_a_ready), 64'd0);
    checkOutput("rst_s_a_valid", 64'(s_a_valid), 64'd0);
    checkOutput("rst_s_d_ready", 64'(s_d_ready), 64'd0);
    checkOutput("rst_m_d_valid", 64'(m_d_valid), 64'd0);
    checkOutput("rst_err_unexp", 64'(err_unexpected_d), 64'd0);
    m_a_valid = 3'b000;
    s_d_valid = 1'b0;
    aQueue.delete();
    dQueue.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    m_a_valid = '0; m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
    m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_d_ready = '0;
    s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0;
    s_d_source = '0; s_d_sink = '0; s_d_data = '0; s_d_error = 1'b0;
    reset_n = 1'b0;
    applyReset();

    // Single Get from master 1, then its response, then a repeat of the same D once pending is gone.
    nextCycle();
    applyStimulus(1, 3'd4, 2'd3, 32'h10, 32'h0);
    expectA(2'd1, 32'h10, 3'd4, 32'h0);
    waitGrant(1);
    nextCycle();
    m_a_valid = 3'b000;
    @(negedge clk);
    checkA();
    checkOutput("hold_m_a_ready", 64'(m_a_ready), 64'd0);
    s_a_ready = 1'b1;
    nextCycle();
    s_a_ready = 1'b0;
    m_d_ready = 3'b010;
    driveD(2'd1, 32'hDEAD_BEEF, 3'd1);
    expectD(1, 2'd3, 32'hDEAD_BEEF, 3'd1, 1'b0);
    @(negedge clk);
    checkD();
    checkOutput("t1_s_d_ready", 64'(s_d_ready), 64'd1);
    checkOutput("t1_err_unexp", 64'(err_unexpected_d), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_cleared_m_d_valid", 64'(m_d_valid), 64'd0);
    checkOutput("t1_cleared_err", 64'(err_unexpected_d), 64'd1);
    nextCycle();
    s_d_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_err_once", 64'(err_unexpected_d), 64'd0);

    // All three masters request continuously; each is answered right after its A beat leaves.
    applyReset();
    nextCycle();
    for (int i = 0; i < 3; i++) applyStimulus(i, 3'd4, 2'(3 - i), 32'h100 + 32'(i * 4), 32'h0);
    m_d_ready = 3'b111;
    prev = -1;
    for (int n = 0; n < 6; n++) begin
      expectA(2'(order[n]), 32'h100 + 32'(order[n] * 4), 3'd4, 32'h0);
      waitGrant(order[n]);
      if (prev >= 0) checkD();
      nextCycle();
      s_d_valid = 1'b0;
      @(negedge clk);
      checkA();
      checkOutput("rr_hold_ready", 64'(m_a_ready), 64'd0);
      s_a_ready = 1'b1;
      nextCycle();
      s_a_ready = 1'b0;
      driveD(2'(order[n]), 32'hA000 + 32'(n), 3'd1);
      expectD(order[n], 2'(3 - order[n]), 32'hA000 + 32'(n), 3'd1, 1'b0);
      prev = order[n];
    end
    m_a_valid = 3'b000;
    @(negedge clk);
    checkD();
    nextCycle();
    s_d_valid = 1'b0;

    // Downstream back-pressure: the held beat must not move and no master may be accepted.
    applyStimulus(2, 3'd0, 2'd1, 32'h44, 32'h1234_5678);
    expectA(2'd2, 32'h44, 3'd0, 32'h1234_5678);
    waitGrant(2);
    nextCycle();
    m_a_valid = 3'b011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_s_a_valid", 64'(s_a_valid), 64'd1);
      checkOutput("stall_s_a_address", 64'(s_a_address), 64'h44);
      checkOutput("stall_s_a_data", 64'(s_a_data), 64'h1234_5678);
      checkOutput("stall_s_a_source", 64'(s_a_source), 64'd2);
      checkOutput("stall_m_a_ready", 64'(m_a_ready), 64'd0);
      nextCycle();
    end
    @(negedge clk);
    checkA();
    s_a_ready = 1'b1;
    nextCycle();
    s_a_ready = 1'b0;
    m_a_valid = 3'b000;
    m_d_ready = 3'b100;
    driveD(2'd2, 32'h0, 3'd0);
    expectD(2, 2'd1, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    checkD();
    nextCycle();
    s_d_valid = 1'b0;

    // Unexpected D beats: out-of-range source, and a master with nothing outstanding.
    m_d_ready = 3'b000;
    for (int k = 0; k < 2; k++) begin
      driveD((k == 0) ? 2'd3 : 2'd0, 32'h5555, 3'd0);
      @(negedge clk);
      checkOutput("unexp_s_d_ready", 64'(s_d_ready), 64'd1);
      checkOutput("unexp_err", 64'(err_unexpected_d), 64'd1);
      checkOutput("unexp_m_d_valid", 64'(m_d_valid), 64'd0);
      nextCycle();
      s_d_valid = 1'b0;
      @(negedge clk);
      checkOutput("unexp_err_once", 64'(err_unexpected_d), 64'd0);
      nextCycle();
    end

`ifdef ADDR_DECODE_ERR_EN
    // Out-of-range Get is answered locally; A accepts stall and a stray D to that master is dropped.
    applyStimulus(2, 3'd4, 2'd2, 32'h2000, 32'h0);
    expectD(2, 2'd2, 32'h0, 3'd1, 1'b1);
    waitGrant(2);
    nextCycle();
    m_a_valid = 3'b001;
    driveD(2'd2, 32'hFFFF_0000, 3'd1);
    @(negedge clk);
    checkOutput("dec_s_a_valid", 64'(s_a_valid), 64'd0);
    checkOutput("dec_stall_ready", 64'(m_a_ready), 64'd0);
    checkOutput("dec_m_d_valid_held", 64'(m_d_valid), 64'd4);
    checkOutput("dec_data_zero", 64'(m_d_data[2*DW +: DW]), 64'd0);
    checkOutput("dec_stray_d", 64'(err_unexpected_d), 64'd1);
    nextCycle();
    s_d_valid = 1'b0;
    m_a_valid = 3'b000;
    m_d_ready = 3'b100;
    @(negedge clk);
    checkD();
    nextCycle();
    m_d_ready = 3'b000;
    @(negedge clk);
    checkOutput("dec_done_m_d_valid", 64'(m_d_valid), 64'd0);
    checkOutput("dec_no_fwd", 64'(s_a_valid), 64'd0);
    nextCycle();
`endif

    // Reset while a beat is held downstream: everything drops and master 0 wins first afterwards.
    applyStimulus(1, 3'd4, 2'd2, 32'h80, 32'h0);
    expectA(2'd1, 32'h80, 3'd4, 32'h0);
    waitGrant(1);
    nextCycle();
    m_a_valid = 3'b000;
    @(negedge clk);
    checkA();
    #2;
    reset_n   = 1'b0;
    m_a_valid = 3'b111;
    driveD(2'd1, 32'h77, 3'd1);
    #1;
    checkOutput("mid_rst_s_a_valid", 64'(s_a_valid), 64'd0);
    checkOutput("mid_rst_m_a_ready", 64'(m_a_ready), 64'd0);
    checkOutput("mid_rst_s_d_ready", 64'(s_d_ready), 64'd0);
    checkOutput("mid_rst_m_d_valid", 64'(m_d_valid), 64'd0);
    @(negedge clk);
    m_a_valid = 3'b000;
    s_d_valid = 1'b0;
    reset_n   = 1'b1;
    nextCycle();
    m_d_ready = 3'b111;
    driveD(2'd1, 32'h77, 3'd1);
    @(negedge clk);
    checkOutput("post_rst_pending_err", 64'(err_unexpected_d), 64'd1);
    checkOutput("post_rst_m_d_valid", 64'(m_d_valid), 64'd0);
    nextCycle();
    s_d_valid = 1'b0;
    applyStimulus(0, 3'd4, 2'd1, 32'h200, 32'h0);
    m_a_valid = 3'b111;
    expectA(2'd0, 32'h200, 3'd4, 32'h0);
    waitGrant(0);
    nextCycle();
    m_a_valid = 3'b000;
    @(negedge clk);
    checkA();
    s_a_ready = 1'b1;
    nextCycle();
    s_a_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
